// File: rtl/tree_noc_pkg.sv
// Shared definitions for the traffic generator: pattern encodings, flit layout, FSM states.
// No logic; consumed by pe_traffic_gen and lfsr16.
// Flit layout: timestamp in the low DataWidth bits, destination directly above it, zero padding on top.
package tree_noc_pkg;

    // Traffic pattern encodings carried on i_mode; 7 aliases neighbour.
    localparam logic [2:0] MODE_RANDOM     = 3'd0;
    localparam logic [2:0] MODE_COMPLEMENT = 3'd1;
    localparam logic [2:0] MODE_BITREV     = 3'd2;
    localparam logic [2:0] MODE_ROTATE     = 3'd3;
    localparam logic [2:0] MODE_TRANSPOSE  = 3'd4;
    localparam logic [2:0] MODE_TORNADO    = 3'd5;
    localparam logic [2:0] MODE_NEIGHBOUR  = 3'd6;

    // Flit field offsets.
    localparam int FLIT_TS_LSB = 0;

    function automatic int flit_dest_lsb(input int data_width);
        return data_width;
    endfunction

    // Right-shifting Galois mask for x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_SEND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR; advances one step per cycle while en is high.
// Ports: clk, rst (async active-low, loads seed), en, seed, state (current value).
// No backpressure; state is registered, so the new value appears the cycle after en.
module lfsr16
    import tree_noc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/pe_traffic_gen.sv
// Synthetic NoC traffic source/sink for one PE: injects PktLimit timestamped flits, measures receive latency.
// Ports: i_data/i_data_valid/o_data_ready receive side; o_data/o_data_valid/i_data_ready transmit side;
//        i_start/i_mode/i_rate run control; o_done, o_sent_count, o_recv_count, o_latency_sum/max status.
// Flit registered one cycle after the inject decision, held stable while i_data_ready is low; sink always ready.
module pe_traffic_gen
    import tree_noc_pkg::*;
#(
    parameter int Address      = 0,
    parameter int NumPE        = 4,
    parameter int AddressWidth = 2,
    parameter int DataWidth    = 32,
    parameter int TotalWidth   = 35,
    parameter int PktLimit     = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TotalWidth-1:0]   i_data,
    input  logic                    i_data_valid,
    output logic                    o_data_ready,
    output logic [TotalWidth-1:0]   o_data,
    output logic                    o_data_valid,
    input  logic                    i_data_ready,
    input  logic                    i_start,
    input  logic [2:0]              i_mode,
    input  logic [7:0]              i_rate,
    output logic                    o_done,
    output logic [31:0]             o_sent_count,
    output logic [31:0]             o_recv_count,
    output logic [DataWidth+15:0]   o_latency_sum,
    output logic [DataWidth-1:0]    o_latency_max
);

    localparam int DestLsb = flit_dest_lsb(DataWidth);
    localparam int TornadoDst   = (Address + (NumPE + 1) / 2) % NumPE;
    localparam int NeighbourDst = (Address + 1) % NumPE;
    localparam logic [AddressWidth-1:0] AddrBits = AddressWidth'(Address);
    localparam logic [31:0] PktLimitW = 32'(PktLimit);
    localparam logic [15:0] Seed = 16'(Address + 1);

    state_e                  state_q, state_d;
    logic [2:0]              mode_q, mode_d;
    logic [TotalWidth-1:0]   data_q, data_d;
    logic                    vld_q, vld_d;
    logic [31:0]             sent_q, sent_d;
    logic [DataWidth-1:0]    cnt_q;
    logic [31:0]             recv_q;
    logic [DataWidth+15:0]   lat_sum_q;
    logic [DataWidth-1:0]    lat_max_q;

    logic [15:0]             lfsr;
    logic                    inject;
    logic [AddressWidth-1:0] dest;
    logic [TotalWidth-1:0]   flit;
    logic [DataWidth-1:0]    lat;
    logic [DataWidth+16:0]   lat_sum_ext;
    logic                    unused_bits;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q != ST_IDLE),
        .seed  (Seed),
        .state (lfsr)
    );

    // Only lfsr[15:8] and the low destination bits feed logic; the
    // upper flit bits carry no receive information.
    assign unused_bits = ^{lfsr, i_data[TotalWidth-1:DataWidth]};

    always_comb begin
        dest = '0;
        case (mode_q)
            MODE_RANDOM:     dest = lfsr[AddressWidth-1:0];
            MODE_COMPLEMENT: dest = ~AddrBits;
            MODE_BITREV:     dest = {<<{AddrBits}};
            MODE_ROTATE:     dest = (AddrBits >> 1) | (AddrBits << (AddressWidth - 1));
            MODE_TRANSPOSE:  dest = (AddrBits >> (AddressWidth / 2))
                                  | (AddrBits << (AddressWidth - AddressWidth / 2));
            MODE_TORNADO:    dest = AddressWidth'(TornadoDst);
            default:         dest = AddressWidth'(NeighbourDst);
        endcase
    end

    always_comb begin
        flit = '0;
        flit[FLIT_TS_LSB +: DataWidth] = cnt_q;
        flit[DestLsb +: AddressWidth]  = dest;
    end

    assign inject = (i_rate == 8'hFF) || (lfsr[15:8] < i_rate);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        vld_d   = vld_q;
        sent_d  = sent_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    sent_d  = '0;
                    mode_d  = i_mode;
                    state_d = (PktLimit == 0) ? ST_DONE : ST_GEN;
                end
            end
            ST_GEN: begin
                if (inject) begin
                    data_d  = flit;
                    vld_d   = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // Dropping valid on acceptance guarantees an idle cycle
                // between flits, since GEN needs a cycle to re-inject.
                if (i_data_ready) begin
                    sent_d  = sent_q + 32'd1;
                    vld_d   = 1'b0;
                    state_d = (sent_d == PktLimitW) ? ST_DONE : ST_GEN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            sent_q  <= sent_d;
        end
    end

    // Receive path: latency is modulo the counter width, so a timestamp
    // taken just before a wrap still yields a small positive latency.
    assign lat         = cnt_q - i_data[DataWidth-1:0];
    assign lat_sum_ext = {1'b0, lat_sum_q} + {17'b0, lat};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            recv_q    <= '0;
            lat_sum_q <= '0;
            lat_max_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (i_data_valid) begin
                recv_q    <= recv_q + 32'd1;
                lat_sum_q <= lat_sum_ext[DataWidth+16] ? '1 : lat_sum_ext[DataWidth+15:0];
                if (lat > lat_max_q) begin
                    lat_max_q <= lat;
                end
            end
        end
    end

    assign o_data_ready  = 1'b1;
    assign o_data        = data_q;
    assign o_data_valid  = vld_q;
    assign o_done        = (state_q == ST_DONE);
    assign o_sent_count  = sent_q;
    assign o_recv_count  = recv_q;
    assign o_latency_sum = lat_sum_q;
    assign o_latency_max = lat_max_q;

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Directed bench for pe_traffic_gen using four instances with different address/limit parameters.
// Latency: not applicable (testbench).
// Backpressure: stalls are driven on i_data_ready directly.
module tb_pe_traffic_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    // A: Address 1, PktLimit 3
    logic [34:0] a_i_data;
    logic        a_i_data_valid, a_o_data_ready, a_o_data_valid, a_i_data_ready;
    logic [34:0] a_o_data;
    logic        a_i_start, a_o_done;
    logic [2:0]  a_i_mode;
    logic [7:0]  a_i_rate;
    logic [31:0] a_o_sent, a_o_recv, a_o_lmax;
    logic [47:0] a_o_lsum;
    // B: Address 0, PktLimit 1000
    logic [34:0] b_i_data;
    logic        b_i_data_valid, b_o_data_ready, b_o_data_valid, b_i_data_ready;
    logic [34:0] b_o_data;
    logic        b_i_start, b_o_done;
    logic [2:0]  b_i_mode;
    logic [7:0]  b_i_rate;
    logic [31:0] b_o_sent, b_o_recv, b_o_lmax;
    logic [47:0] b_o_lsum;
    // C: Address 2, 16 PEs, padded flit, PktLimit 1
    logic [37:0] c_i_data;
    logic        c_i_data_valid, c_o_data_ready, c_o_data_valid, c_i_data_ready;
    logic [37:0] c_o_data;
    logic        c_i_start, c_o_done;
    logic [2:0]  c_i_mode;
    logic [7:0]  c_i_rate;
    logic [31:0] c_o_sent, c_o_recv, c_o_lmax;
    logic [47:0] c_o_lsum;
    // D: Address 3, PktLimit 0
    logic [34:0] d_i_data;
    logic        d_i_data_valid, d_o_data_ready, d_o_data_valid, d_i_data_ready;
    logic [34:0] d_o_data;
    logic        d_i_start, d_o_done;
    logic [2:0]  d_i_mode;
    logic [7:0]  d_i_rate;
    logic [31:0] d_o_sent, d_o_recv, d_o_lmax;
    logic [47:0] d_o_lsum;

    pe_traffic_gen #(.Address(1), .NumPE(4), .AddressWidth(2), .DataWidth(32), .TotalWidth(35), .PktLimit(3)) u_a (
        .clk(clk), .rst(rst), .i_data(a_i_data), .i_data_valid(a_i_data_valid), .o_data_ready(a_o_data_ready),
        .o_data(a_o_data), .o_data_valid(a_o_data_valid), .i_data_ready(a_i_data_ready), .i_start(a_i_start),
        .i_mode(a_i_mode), .i_rate(a_i_rate), .o_done(a_o_done), .o_sent_count(a_o_sent), .o_recv_count(a_o_recv),
        .o_latency_sum(a_o_lsum), .o_latency_max(a_o_lmax));

    pe_traffic_gen #(.Address(0), .NumPE(4), .AddressWidth(2), .DataWidth(32), .TotalWidth(35), .PktLimit(1000)) u_b (
        .clk(clk), .rst(rst), .i_data(b_i_data), .i_data_valid(b_i_data_valid), .o_data_ready(b_o_data_ready),
        .o_data(b_o_data), .o_data_valid(b_o_data_valid), .i_data_ready(b_i_data_ready), .i_start(b_i_start),
        .i_mode(b_i_mode), .i_rate(b_i_rate), .o_done(b_o_done), .o_sent_count(b_o_sent), .o_recv_count(b_o_recv),
        .o_latency_sum(b_o_lsum), .o_latency_max(b_o_lmax));

    pe_traffic_gen #(.Address(2), .NumPE(16), .AddressWidth(4), .DataWidth(32), .TotalWidth(38), .PktLimit(1)) u_c (
        .clk(clk), .rst(rst), .i_data(c_i_data), .i_data_valid(c_i_data_valid), .o_data_ready(c_o_data_ready),
        .o_data(c_o_data), .o_data_valid(c_o_data_valid), .i_data_ready(c_i_data_ready), .i_start(c_i_start),
        .i_mode(c_i_mode), .i_rate(c_i_rate), .o_done(c_o_done), .o_sent_count(c_o_sent), .o_recv_count(c_o_recv),
        .o_latency_sum(c_o_lsum), .o_latency_max(c_o_lmax));

    pe_traffic_gen #(.Address(3), .NumPE(4), .AddressWidth(2), .DataWidth(32), .TotalWidth(35), .PktLimit(0)) u_d (
        .clk(clk), .rst(rst), .i_data(d_i_data), .i_data_valid(d_i_data_valid), .o_data_ready(d_o_data_ready),
        .o_data(d_o_data), .o_data_valid(d_o_data_valid), .i_data_ready(d_i_data_ready), .i_start(d_i_start),
        .i_mode(d_i_mode), .i_rate(d_i_rate), .o_done(d_o_done), .o_sent_count(d_o_sent), .o_recv_count(d_o_recv),
        .o_latency_sum(d_o_lsum), .o_latency_max(d_o_lmax));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    int seq_buf [1000];
    int seq1 [1000];

    task automatic run_b(output int nf, output int gaps);
        logic prev;
        b_i_mode = 3'd0; b_i_rate = 8'hFF; b_i_data_ready = 1'b1;
        b_i_start = 1'b1; tick(); b_i_start = 1'b0;
        nf = 0; gaps = 0; prev = 1'b0;
        for (int k = 0; k < 2300 && !b_o_done; k++) begin
            tick();
            if (b_o_data_valid) begin
                if (prev) gaps++;
                if (nf < 1000) seq_buf[nf] = int'(b_o_data[33:32]);
                nf++;
            end
            prev = b_o_data_valid;
        end
    endtask

    initial begin
        int c0, nf, gaps, bad, diffs, cnt, mism, seen;
        logic prev;
        logic [34:0] first;
        logic [31:0] ts [8];
        logic [15:0] m;
        int c_exp [8] = '{0, 13, 4, 1, 8, 10, 3, 3};

        a_i_data = '0; a_i_data_valid = 0; a_i_data_ready = 1; a_i_start = 0; a_i_mode = 0; a_i_rate = 0;
        b_i_data = '0; b_i_data_valid = 0; b_i_data_ready = 1; b_i_start = 0; b_i_mode = 0; b_i_rate = 0;
        c_i_data = '0; c_i_data_valid = 0; c_i_data_ready = 1; c_i_start = 0; c_i_mode = 0; c_i_rate = 8'hFF;
        d_i_data = '0; d_i_data_valid = 0; d_i_data_ready = 1; d_i_start = 0; d_i_mode = 0; d_i_rate = 8'hFF;

        // Reset state, observed while reset is asserted before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("rst_valid", a_o_data_valid, 0);
        check("rst_data", a_o_data, 0);
        check("rst_done", a_o_done, 0);
        check("rst_counts", {a_o_sent, a_o_recv}, 0);
        check("rst_lat", {a_o_lsum[15:0], a_o_lmax}, 0);
        check("sink_ready", a_o_data_ready, 1);
        reset_dut();

        // Receive latency, including a timestamp from before counter wrap.
        while (cyc < 4) tick();
        a_i_data = 35'h0_FFFF_FFFD; a_i_data_valid = 1'b1; tick(); a_i_data_valid = 1'b0;
        check("rx1_recv", a_o_recv, 1);
        check("rx1_max", a_o_lmax, 7);
        check("rx1_sum", a_o_lsum, 7);
        while (cyc < 25) tick();
        a_i_data = 35'd10; a_i_data_valid = 1'b1; tick(); a_i_data_valid = 1'b0;
        check("rx2_recv", a_o_recv, 2);
        check("rx2_max", a_o_lmax, 15);
        check("rx2_sum", a_o_lsum, 22);

        // Complement run, three flits at full rate.
        a_i_mode = 3'd1; a_i_rate = 8'hFF; a_i_data_ready = 1'b1;
        c0 = cyc;
        a_i_start = 1'b1; tick(); a_i_start = 1'b0;
        nf = 0; gaps = 0; bad = 0; prev = 1'b0;
        for (int k = 0; k < 40 && !a_o_done; k++) begin
            tick();
            if (a_o_data_valid) begin
                if (prev) gaps++;
                if (a_o_data[34:32] != 3'd2) bad++;
                if (nf < 8) ts[nf] = a_o_data[31:0];
                nf++;
            end
            prev = a_o_data_valid;
        end
        check("run_flits", nf, 3);
        check("run_dest", bad, 0);
        check("run_gap", gaps, 0);
        check("run_ts0", ts[0], c0 + 1);
        check("run_ts1", ts[1], c0 + 3);
        check("run_ts2", ts[2], c0 + 5);
        check("run_sent", a_o_sent, 3);
        check("run_done", a_o_done, 1);

        // Stall: flit must stay bit-identical until accepted.
        a_i_data_ready = 1'b0;
        a_i_start = 1'b1; tick(); a_i_start = 1'b0;
        for (int k = 0; k < 10 && !a_o_data_valid; k++) tick();
        check("stall_vld", a_o_data_valid, 1);
        first = a_o_data;
        diffs = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (a_o_data !== first || a_o_data_valid !== 1'b1) diffs++;
        end
        check("stall_hold", diffs, 0);
        check("stall_sent", a_o_sent, 0);
        a_i_data_ready = 1'b1; tick();
        check("stall_drop", a_o_data_valid, 0);
        check("stall_acc", a_o_sent, 1);
        for (int k = 0; k < 40 && !a_o_done; k++) tick();
        check("stall_done", a_o_sent, 3);

        // Rate 0: generator parks in GEN without injecting.
        a_i_rate = 8'h00;
        a_i_start = 1'b1; tick(); a_i_start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (a_o_data_valid || a_o_done) cnt++;
        end
        check("rate0_quiet", cnt, 0);
        check("rate0_sent", a_o_sent, 0);
        a_i_rate = 8'hFF;
        for (int k = 0; k < 40 && !a_o_done; k++) tick();
        check("rate0_resume", a_o_sent, 3);

        // PktLimit 0: start goes straight to DONE.
        check("lim0_idle", d_o_done, 0);
        d_i_start = 1'b1; tick(); d_i_start = 1'b0;
        check("lim0_done", d_o_done, 1);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (d_o_data_valid) cnt++;
        end
        check("lim0_novld", cnt, 0);

        // Deterministic patterns on a 16-PE node at address 2.
        bad = 0;
        for (int md = 1; md < 8; md++) begin
            c_i_mode = 3'(md);
            c_i_start = 1'b1; tick(); c_i_start = 1'b0;
            for (int k = 0; k < 10 && !c_o_data_valid; k++) tick();
            check($sformatf("mode%0d_dest", md), c_o_data[35:32], c_exp[md]);
            if (c_o_data[37:36] != 2'b00) bad++;
            for (int k = 0; k < 10 && !c_o_done; k++) tick();
        end
        check("mode_pad0", bad, 0);

        // Asynchronous reset while a flit is pending.
        a_i_data_ready = 1'b0;
        a_i_start = 1'b1; tick(); a_i_start = 1'b0;
        for (int k = 0; k < 10 && !a_o_data_valid; k++) tick();
        check("mid_vld", a_o_data_valid, 1);
        #3 rst = 1'b0;
        #1;
        check("arst_vld", a_o_data_valid, 0);
        check("arst_data", a_o_data, 0);
        check("arst_counts", {a_o_sent, a_o_recv}, 0);
        check("arst_lat", {a_o_lsum[15:0], a_o_lmax}, 0);
        @(negedge clk);
        rst = 1'b1; cyc = 0;
        a_i_data_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (a_o_data_valid || a_o_done) cnt++;
        end
        check("arst_idle", cnt, 0);

        // Random pattern: full coverage and reproducibility across resets.
        reset_dut();
        run_b(nf, gaps);
        check("rnd_flits", nf, 1000);
        check("rnd_gap", gaps, 0);
        check("rnd_sent", b_o_sent, 1000);
        check("rnd_done", b_o_done, 1);
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            seen = seen | (1 << seq_buf[i]);
            seq1[i] = seq_buf[i];
        end
        check("rnd_cover", seen, 15);
        m = 16'h0001;
        mism = 0;
        for (int i = 0; i < 16; i++) begin
            if (seq_buf[i] != int'(m[1:0])) mism++;
            m = lfsr_step(lfsr_step(m));
        end
        check("rnd_lfsr", mism, 0);
        reset_dut();
        run_b(nf, gaps);
        mism = 0;
        for (int i = 0; i < 1000; i++) if (seq_buf[i] != seq1[i]) mism++;
        check("rnd_repeat", mism, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
